retire_trace_buffer: RTL and testbench
======================================

Name: retire_trace_buffer

Overview:
- Parametrised capture buffer for the pipelined RISC-V core. It records one entry per retired instruction: PC, instruction word, write-back data and rd.
- Entries go into a circular on-chip buffer with a PC-match trigger and a post-trigger window. Once frozen, the contents drain over a valid/ready port.
- Sits beside the write-back stage. It replaces the ad-hoc probe wires (PC_out, instruction, write data) that are currently brought out of the core top.

Parameters:
- XLEN, 64, datapath / PC width
- ILEN, 32, instruction width
- DEPTH, 16, entry count; power of 2, minimum 4
- POST_DEFAULT, 8, post-trigger entries captured when cfg_post is 0

Ports:
- clk  in  1  core clock, rising edge
- reset  in  1  asynchronous, active-low
- ret_valid  in  1  one instruction retires this cycle
- ret_pc  in  XLEN  PC of the retiring instruction
- ret_instr  in  ILEN  instruction word
- ret_wdata  in  XLEN  write-back data
- ret_rd  in  5  destination register
- ret_wen  in  1  register write enable
- arm  in  1  one-cycle pulse: clear buffer and start capture
- cfg_wrap  in  1  1 = overwrite oldest entry when full; 0 = stop when full
- cfg_trig_en  in  1  enable PC-match trigger
- cfg_trig_pc  in  XLEN  trigger PC
- cfg_post  in  $clog2(DEPTH)+1  post-trigger count; 0 selects POST_DEFAULT
- rd_valid  out  1  drain entry available
- rd_ready  in  1  consumer accepts entry
- rd_pc, rd_instr, rd_wdata, rd_rd, rd_wen  out  matching widths  oldest entry
- count  out  $clog2(DEPTH)+1  entries currently held
- triggered  out  1  trigger seen since arm
- overflow  out  1  at least one entry lost, by overwrite or by stop-when-full
- state_o  out  2  current FSM state

Behaviour:
- Reset (reset=0): state IDLE; wr_ptr=rd_ptr=count=0; triggered=overflow=0; rd_valid=0; all rd_* outputs 0. Buffer RAM is not reset.
- States and encodings: IDLE 0, CAPTURE 1, POST 2, FROZEN 3.
- arm pulse, accepted in any state: clears pointers, count, triggered and overflow; enters CAPTURE next cycle. If arm and ret_valid occur in the same cycle, the entry is dropped.
- CAPTURE, on ret_valid: write entry at wr_ptr; wr_ptr increments and wraps modulo DEPTH.
  - count below DEPTH: count increments.
  - count equal to DEPTH, cfg_wrap=1: write proceeds; rd_ptr advances; overflow set.
  - count equal to DEPTH, cfg_wrap=0: write suppressed; overflow set; go to FROZEN.
- Trigger: in CAPTURE with cfg_trig_en=1, ret_valid and ret_pc==cfg_trig_pc:
  - the triggering entry is written and triggered is set;
  - load post counter = (cfg_post==0 ? POST_DEFAULT : cfg_post) and go to POST.
  - If the effective post count is 0, go directly to FROZEN after writing.
- POST: each ret_valid writes as in CAPTURE and decrements the post counter.
  - When the counter reaches 0 after the write, go to FROZEN.
  - Further PC matches are ignored.
- FROZEN: ret_* inputs ignored.
  - rd_valid=(count!=0); rd_* shows the entry at rd_ptr, registered, 1-cycle read latency after each pop.
  - Handshake rd_valid and rd_ready pops: rd_ptr increments and count decrements.
  - rd_valid and the rd_* data hold stable while rd_ready=0.
- IDLE and CAPTURE/POST: rd_valid=0; drain is not permitted during capture.
- Reset mid-capture or mid-drain returns to IDLE immediately (asynchronous). No partial state is retained.
- Pointer width is $clog2(DEPTH). count width is one bit wider so that a full buffer (count==DEPTH) is representable.

Optional Feature:
- Macro: RETIRE_TRACE_TIMESTAMP_EN.
- Defined:
  - 32-bit cycle counter, reset to 0 and cleared on arm, increments every clk while not IDLE.
  - Each entry also stores the cycle count, exposed on output rd_ts[31:0].
  - Counter saturates at 32'hFFFF_FFFF.
- Undefined: no counter, no rd_ts port, entry width reduced accordingly.

Decomposition:
- Package retire_trace_pkg holds:
  - state enum constants: IDLE, CAPTURE, POST, FROZEN;
  - the entry-width localparam computed from XLEN, ILEN, 5, 1 and the optional 32;
  - the default XLEN and ILEN constants.
- One sub-module, trace_ram: simple dual-port RAM with synchronous write and registered read, parametrised by width and DEPTH.

Test Plan:
- Basic capture, then drain: arm; 5 retires with PC 0x0,0x4,…,0x10, trig disabled; force FROZEN by 11 more retires with cfg_wrap=0 plus one extra. Expected: count=16, overflow=1, drain yields PC 0x0 first and 0x3C last, rd_valid drops after 16 pops.
- Wrap mode: DEPTH=16, cfg_wrap=1, trig at PC 0x50 with cfg_post=2; 24 retires PC 0x0..0x5C step 4. Expected: trigger at entry 21, freeze after PC 0x58, count=16, first drained PC 0x1C, overflow=1.
- Post default: cfg_post=0, trigger on first retire. Expected: freeze after 9 entries (trigger + 8), count=9, triggered=1.
- Backpressure: in FROZEN hold rd_ready=0 for 5 cycles, then toggle it. Expected: rd_pc stable while stalled, no entry skipped or duplicated.
- Arm collision and async reset: arm coincident with ret_valid, expect count=0. Then reset low mid-POST, expect state_o=0, rd_valid=0 and count=0 before the next clk edge.
- With RETIRE_TRACE_TIMESTAMP_EN: retires on cycles 3, 4 and 7 after arm. Expected: rd_ts values 3, 4, 7.

Source files
------------

// File: rtl/retire_trace_pkg.sv
// Shared types and sizing for the retire trace buffer.
// Entry width grows by a 32-bit timestamp when RETIRE_TRACE_TIMESTAMP_EN is defined.
package retire_trace_pkg;
    localparam int XLEN_DEF = 64;
    localparam int ILEN_DEF = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        POST    = 2'd2,
        FROZEN  = 2'd3
    } trace_state_e;

`ifdef RETIRE_TRACE_TIMESTAMP_EN
    localparam int TS_W = 32;
`else
    localparam int TS_W = 0;
`endif

    // Entry layout, LSB first: pc, instr, wdata, rd, wen, [ts]
    function automatic int entry_w(input int xlen, input int ilen);
        return xlen + ilen + xlen + 5 + 1 + TS_W;
    endfunction

    localparam int ENTRY_W = entry_w(XLEN_DEF, ILEN_DEF);
endpackage

// File: rtl/trace_ram.sv
// Simple dual-port entry store: synchronous write, registered read with write-through.
// Latency: read data valid one cycle after raddr is presented with re high.
// Backpressure: none; read register holds its value while re is low.
module trace_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q, rdata_d;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Forward a same-cycle write so the final capture is visible on the first drain beat
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = (we && (waddr == raddr)) ? wdata : mem[raddr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/retire_trace_buffer.sv
// Retire trace capture: circular buffer with PC trigger, post-trigger window and drain port.
// Latency: rd_* registered, next entry presented the cycle after each pop; optional rd_ts via RETIRE_TRACE_TIMESTAMP_EN.
// Backpressure: rd_valid/rd_* hold while rd_ready is low; drain only in FROZEN.
module retire_trace_buffer
    import retire_trace_pkg::*;
#(
    parameter int XLEN         = XLEN_DEF,
    parameter int ILEN         = ILEN_DEF,
    parameter int DEPTH        = 16,
    parameter int POST_DEFAULT = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ret_valid,
    input  logic [XLEN-1:0]          ret_pc,
    input  logic [ILEN-1:0]          ret_instr,
    input  logic [XLEN-1:0]          ret_wdata,
    input  logic [4:0]               ret_rd,
    input  logic                     ret_wen,
    input  logic                     arm,
    input  logic                     cfg_wrap,
    input  logic                     cfg_trig_en,
    input  logic [XLEN-1:0]          cfg_trig_pc,
    input  logic [$clog2(DEPTH):0]   cfg_post,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [XLEN-1:0]          rd_pc,
    output logic [ILEN-1:0]          rd_instr,
    output logic [XLEN-1:0]          rd_wdata,
    output logic [4:0]               rd_rd,
    output logic                     rd_wen,
`ifdef RETIRE_TRACE_TIMESTAMP_EN
    output logic [31:0]              rd_ts,
`endif
    output logic [$clog2(DEPTH):0]   count,
    output logic                     triggered,
    output logic                     overflow,
    output logic [1:0]               state_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = entry_w(XLEN, ILEN);

    trace_state_e  state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d, post_q, post_d, eff_post;
    logic          trig_q, trig_d, ovf_q, ovf_d;
    logic          full, trig_hit, ram_we, ram_re;
    logic [EW-1:0] wr_entry, rd_entry;

`ifdef RETIRE_TRACE_TIMESTAMP_EN
    logic [31:0] ts_q, ts_d;

    always_comb begin
        ts_d = ts_q;
        if (arm) begin
            ts_d = '0;
        end else if ((state_q != IDLE) && (ts_q != 32'hFFFF_FFFF)) begin
            ts_d = ts_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_d;
        end
    end

    assign wr_entry = {ts_q, ret_wen, ret_rd, ret_wdata, ret_instr, ret_pc};
    assign rd_ts    = rd_entry[2*XLEN+ILEN+6 +: 32];
`else
    assign wr_entry = {ret_wen, ret_rd, ret_wdata, ret_instr, ret_pc};
`endif

    assign full     = (count_q == CW'(DEPTH));
    assign trig_hit = cfg_trig_en && (ret_pc == cfg_trig_pc);
    assign eff_post = (cfg_post == '0) ? CW'(POST_DEFAULT) : cfg_post;
    assign rd_valid = (state_q == FROZEN) && (count_q != '0);

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        post_d   = post_q;
        trig_d   = trig_q;
        ovf_d    = ovf_q;
        ram_we   = 1'b0;
        if (arm) begin
            state_d  = CAPTURE;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            post_d   = '0;
            trig_d   = 1'b0;
            ovf_d    = 1'b0;
        end else begin
            case (state_q)
                CAPTURE, POST: begin
                    if (ret_valid) begin
                        if (full && !cfg_wrap) begin
                            ovf_d   = 1'b1;
                            state_d = FROZEN;
                        end else begin
                            ram_we   = 1'b1;
                            wr_ptr_d = wr_ptr_q + 1'b1;
                            if (full) begin
                                rd_ptr_d = rd_ptr_q + 1'b1;
                                ovf_d    = 1'b1;
                            end else begin
                                count_d = count_q + 1'b1;
                            end
                            if (state_q == CAPTURE) begin
                                if (trig_hit) begin
                                    trig_d  = 1'b1;
                                    post_d  = eff_post;
                                    state_d = (eff_post == '0) ? FROZEN : POST;
                                end
                            end else begin
                                post_d = post_q - 1'b1;
                                if (post_q == CW'(1)) begin
                                    state_d = FROZEN;
                                end
                            end
                        end
                    end
                end
                FROZEN: begin
                    if (rd_valid && rd_ready) begin
                        rd_ptr_d = rd_ptr_q + 1'b1;
                        count_d  = count_q - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            post_q   <= '0;
            trig_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            post_q   <= post_d;
            trig_q   <= trig_d;
            ovf_q    <= ovf_d;
        end
    end

    // Read address tracks the next head so rd_* always shows mem[rd_ptr_q] in FROZEN
    assign ram_re = (state_d == FROZEN);

    trace_ram #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .rst_n (reset),
        .we    (ram_we),
        .waddr (wr_ptr_q),
        .wdata (wr_entry),
        .re    (ram_re),
        .raddr (rd_ptr_d),
        .rdata (rd_entry)
    );

    assign rd_pc     = rd_entry[0 +: XLEN];
    assign rd_instr  = rd_entry[XLEN +: ILEN];
    assign rd_wdata  = rd_entry[XLEN+ILEN +: XLEN];
    assign rd_rd     = rd_entry[2*XLEN+ILEN +: 5];
    assign rd_wen    = rd_entry[2*XLEN+ILEN+5];
    assign count     = count_q;
    assign triggered = trig_q;
    assign overflow  = ovf_q;
    assign state_o   = state_q;
endmodule

// File: tb/tb_retire_trace_buffer.sv
// Bench for retire_trace_buffer: scenario table, hand-written corner sequences, randomized run vs queue model.
// Timestamp checks compile in when RETIRE_TRACE_TIMESTAMP_EN is defined.
module tb_retire_trace_buffer;
    import retire_trace_pkg::*;

    localparam int XLEN = 64;
    localparam int ILEN = 32;
    localparam int DEPTH = 16;
    localparam int POST_DEFAULT = 8;
    localparam int CW = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            ret_valid = 1'b0;
    logic [XLEN-1:0] ret_pc = '0;
    logic [ILEN-1:0] ret_instr = '0;
    logic [XLEN-1:0] ret_wdata = '0;
    logic [4:0]      ret_rd = '0;
    logic            ret_wen = 1'b0;
    logic            arm = 1'b0;
    logic            cfg_wrap = 1'b0;
    logic            cfg_trig_en = 1'b0;
    logic [XLEN-1:0] cfg_trig_pc = '0;
    logic [CW-1:0]   cfg_post = '0;
    logic            rd_valid;
    logic            rd_ready = 1'b0;
    logic [XLEN-1:0] rd_pc;
    logic [ILEN-1:0] rd_instr;
    logic [XLEN-1:0] rd_wdata;
    logic [4:0]      rd_rd;
    logic            rd_wen;
    logic [CW-1:0]   count;
    logic            triggered;
    logic            overflow;
    logic [1:0]      state_o;
`ifdef RETIRE_TRACE_TIMESTAMP_EN
    logic [31:0]     rd_ts;
`endif

    always #5 clk = ~clk;

    retire_trace_buffer #(
        .XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH), .POST_DEFAULT(POST_DEFAULT)
    ) dut (
        .clk(clk), .reset(reset),
        .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_instr(ret_instr),
        .ret_wdata(ret_wdata), .ret_rd(ret_rd), .ret_wen(ret_wen),
        .arm(arm), .cfg_wrap(cfg_wrap), .cfg_trig_en(cfg_trig_en),
        .cfg_trig_pc(cfg_trig_pc), .cfg_post(cfg_post),
        .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_pc(rd_pc), .rd_instr(rd_instr), .rd_wdata(rd_wdata),
        .rd_rd(rd_rd), .rd_wen(rd_wen),
`ifdef RETIRE_TRACE_TIMESTAMP_EN
        .rd_ts(rd_ts),
`endif
        .count(count), .triggered(triggered), .overflow(overflow), .state_o(state_o)
    );

    int vec_cnt = 0;
    int err_cnt = 0;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic [63:0] wdata;
        logic [4:0]  rd;
        logic        wen;
    } entry_t;

    typedef struct {
        logic        wrap;
        logic        trig_en;
        logic [63:0] trig_pc;
        logic [4:0]  post;
        int          n;
        int          exp_count;
        logic        exp_trig;
        logic        exp_ovf;
        logic [1:0]  exp_state;
        logic [63:0] first_pc;
    } scen_t;

    // Reference model: the buffer seen as an ordered queue of captured entries
    entry_t mq[$];
    int     m_st = 0;
    bit     m_trig = 0;
    bit     m_ovf = 0;
    int     m_left = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk_instr(input logic [63:0] pc);
        return pc[31:0] ^ 32'h00C0_FFEE;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic arm_pulse();
        arm = 1'b1;
        step();
        arm = 1'b0;
    endtask

    task automatic drive_ret(input logic v, input logic [63:0] pc, input logic [63:0] wd);
        ret_valid = v;
        ret_pc    = pc;
        ret_instr = mk_instr(pc);
        ret_wdata = wd;
        ret_rd    = wd[4:0];
        ret_wen   = wd[5];
    endtask

    task automatic retire(input logic [63:0] pc, input logic [63:0] wd);
        drive_ret(1'b1, pc, wd);
        step();
        ret_valid = 1'b0;
    endtask

    task automatic model_step(input bit a, input bit v, input bit pop, input entry_t e);
        if (a) begin
            mq.delete();
            m_trig = 0;
            m_ovf  = 0;
            m_st   = 1;
        end else if ((m_st == 1 || m_st == 2) && v) begin
            if (mq.size() == DEPTH && !cfg_wrap) begin
                m_ovf = 1;
                m_st  = 3;
            end else begin
                if (mq.size() == DEPTH) begin
                    mq.delete(0);
                    m_ovf = 1;
                end
                mq.push_back(e);
                if (m_st == 1) begin
                    if (cfg_trig_en && e.pc == cfg_trig_pc) begin
                        m_trig = 1;
                        m_left = (cfg_post == 0) ? POST_DEFAULT : int'(cfg_post);
                        m_st   = (m_left == 0) ? 3 : 2;
                    end
                end else begin
                    m_left--;
                    if (m_left == 0) m_st = 3;
                end
            end
        end else if (m_st == 3 && pop && mq.size() > 0) begin
            mq.delete(0);
        end
    endtask

    task automatic check_model();
        bit exp_vld;
        exp_vld = (m_st == 3) && (mq.size() > 0);
        check("rnd_state", 64'(state_o), 64'(m_st));
        check("rnd_count", 64'(count), 64'(mq.size()));
        check("rnd_triggered", 64'(triggered), 64'(m_trig));
        check("rnd_overflow", 64'(overflow), 64'(m_ovf));
        check("rnd_rd_valid", 64'(rd_valid), 64'(exp_vld));
        if (exp_vld) begin
            check("rnd_rd_pc", rd_pc, mq[0].pc);
            check("rnd_rd_wdata", rd_wdata, mq[0].wdata);
            check("rnd_rd_misc", 64'({rd_rd, rd_wen, rd_instr}),
                  64'({mq[0].rd, mq[0].wen, mq[0].instr}));
        end
    endtask

    scen_t tbl[6];

    initial begin
        entry_t e;
        int     idx;

        //            wrap trig_en trig_pc   post n   cnt trig ovf state    first
        tbl[0] = '{1'b0, 1'b0, 64'h0,    5'd0, 17, 16, 1'b0, 1'b1, FROZEN,  64'h0};
        tbl[1] = '{1'b1, 1'b1, 64'h50,   5'd2, 24, 16, 1'b1, 1'b1, FROZEN,  64'h1C};
        tbl[2] = '{1'b0, 1'b1, 64'h0,    5'd0, 12,  9, 1'b1, 1'b0, FROZEN,  64'h0};
        tbl[3] = '{1'b0, 1'b1, 64'h8,    5'd1,  6,  4, 1'b1, 1'b0, FROZEN,  64'h0};
        tbl[4] = '{1'b1, 1'b0, 64'h0,    5'd0, 20, 16, 1'b0, 1'b1, CAPTURE, 64'h10};
        tbl[5] = '{1'b0, 1'b1, 64'h3C,   5'd3, 20, 16, 1'b1, 1'b1, FROZEN,  64'h0};

        // Reset state
        step();
        step();
        check("rst_state", 64'(state_o), 64'(IDLE));
        check("rst_count", 64'(count), 64'd0);
        check("rst_rd_valid", 64'(rd_valid), 64'd0);
        check("rst_triggered", 64'(triggered), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_rd_pc", rd_pc, 64'd0);
        check("rst_rd_wdata", rd_wdata, 64'd0);
        reset = 1'b1;
        step();

        // Retires while IDLE are not captured
        retire(64'h40, 64'h1);
        check("idle_count", 64'(count), 64'd0);
        check("idle_state", 64'(state_o), 64'(IDLE));

        // Scenario table: capture a run of PCs 0,4,8,... then drain everything
        for (int s = 0; s < 6; s++) begin
            cfg_wrap    = tbl[s].wrap;
            cfg_trig_en = tbl[s].trig_en;
            cfg_trig_pc = tbl[s].trig_pc;
            cfg_post    = CW'(tbl[s].post);
            arm_pulse();
            for (int i = 0; i < tbl[s].n; i++) begin
                retire(64'(i * 4), 64'(i) * 64'h1111);
            end
            check($sformatf("s%0d_count", s), 64'(count), 64'(tbl[s].exp_count));
            check($sformatf("s%0d_state", s), 64'(state_o), 64'(tbl[s].exp_state));
            check($sformatf("s%0d_triggered", s), 64'(triggered), 64'(tbl[s].exp_trig));
            check($sformatf("s%0d_overflow", s), 64'(overflow), 64'(tbl[s].exp_ovf));
            check($sformatf("s%0d_rd_valid", s), 64'(rd_valid),
                  64'(tbl[s].exp_state == FROZEN));
            if (tbl[s].exp_state == FROZEN) begin
                rd_ready = 1'b1;
                for (int i = 0; i < tbl[s].exp_count; i++) begin
                    idx = int'(tbl[s].first_pc / 4) + i;
                    check($sformatf("s%0d_drain%0d_vld", s, i), 64'(rd_valid), 64'd1);
                    check($sformatf("s%0d_drain%0d_pc", s, i), rd_pc, 64'(idx * 4));
                    check($sformatf("s%0d_drain%0d_wdata", s, i), rd_wdata, 64'(idx) * 64'h1111);
                    step();
                end
                rd_ready = 1'b0;
                check($sformatf("s%0d_empty_vld", s), 64'(rd_valid), 64'd0);
                check($sformatf("s%0d_empty_count", s), 64'(count), 64'd0);
            end
        end

        // Backpressure: stall, then toggle rd_ready; each entry seen exactly once in order
        cfg_wrap = 1'b0; cfg_trig_en = 1'b1; cfg_trig_pc = 64'h14; cfg_post = CW'(1);
        arm_pulse();
        for (int i = 0; i < 8; i++) retire(64'(i * 4), 64'(i) + 64'h77);
        check("bp_count", 64'(count), 64'd7);
        for (int c = 0; c < 5; c++) begin
            check("bp_stall_vld", 64'(rd_valid), 64'd1);
            check("bp_stall_pc", rd_pc, 64'h0);
            step();
        end
        idx = 0;
        for (int c = 0; c < 40 && idx < 7; c++) begin
            rd_ready = (c % 2 == 1);
            check("bp_vld", 64'(rd_valid), 64'd1);
            check("bp_pc", rd_pc, 64'(idx * 4));
            check("bp_instr", 64'(rd_instr), 64'(mk_instr(64'(idx * 4))));
            step();
            if (rd_ready) idx++;
        end
        rd_ready = 1'b0;
        check("bp_all_popped", 64'(idx), 64'd7);
        check("bp_empty_vld", 64'(rd_valid), 64'd0);

        // Arm coincident with a retire drops that retire
        cfg_trig_en = 1'b0;
        arm = 1'b1;
        drive_ret(1'b1, 64'h8, 64'h5);
        step();
        arm = 1'b0;
        ret_valid = 1'b0;
        check("coll_count", 64'(count), 64'd0);
        check("coll_state", 64'(state_o), 64'(CAPTURE));
        retire(64'h8, 64'h5);
        check("coll_next_count", 64'(count), 64'd1);

        // Asynchronous reset while in POST
        cfg_trig_en = 1'b1; cfg_trig_pc = 64'h100; cfg_post = CW'(5);
        retire(64'h100, 64'h9);
        retire(64'h104, 64'hA);
        check("post_state", 64'(state_o), 64'(POST));
        check("post_count", 64'(count), 64'd3);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("arst_state", 64'(state_o), 64'(IDLE));
        check("arst_count", 64'(count), 64'd0);
        check("arst_rd_valid", 64'(rd_valid), 64'd0);
        check("arst_triggered", 64'(triggered), 64'd0);
        step();
        reset = 1'b1;
        step();

        // Randomized traffic against the queue model
        for (int r = 0; r < 12; r++) begin
            cfg_wrap    = 1'($urandom_range(0, 1));
            cfg_trig_en = ($urandom_range(0, 3) != 0);
            cfg_trig_pc = 64'(4 * $urandom_range(0, 31));
            cfg_post    = CW'($urandom_range(0, 16));
            arm = 1'b1;
            e = '0;
            model_step(1'b1, 1'b0, 1'b0, e);
            step();
            arm = 1'b0;
            check_model();
            for (int c = 0; c < 150; c++) begin
                drive_ret(($urandom_range(0, 3) != 0), 64'(4 * $urandom_range(0, 31)),
                          {$urandom, $urandom});
                rd_ready = 1'($urandom_range(0, 1));
                arm      = ($urandom_range(0, 99) == 0);
                e = '{ret_pc, ret_instr, ret_wdata, ret_rd, ret_wen};
                model_step(arm, ret_valid, rd_ready, e);
                step();
                check_model();
            end
            ret_valid = 1'b0;
            arm       = 1'b0;
            rd_ready  = 1'b0;
        end

`ifdef RETIRE_TRACE_TIMESTAMP_EN
        // Retires on cycles 3, 4, 7 after arm, then 9 closes the post window
        cfg_wrap = 1'b0; cfg_trig_en = 1'b1; cfg_trig_pc = 64'h1C; cfg_post = CW'(1);
        arm_pulse();
        for (int c = 0; c < 10; c++) begin
            drive_ret((c == 3 || c == 4 || c == 7 || c == 9), 64'(c * 4), 64'(c));
            step();
        end
        ret_valid = 1'b0;
        check("ts_count", 64'(count), 64'd4);
        rd_ready = 1'b1;
        check("ts_0", 64'(rd_ts), 64'd3);
        step();
        check("ts_1", 64'(rd_ts), 64'd4);
        step();
        check("ts_2", 64'(rd_ts), 64'd7);
        step();
        check("ts_3", 64'(rd_ts), 64'd9);
        step();
        rd_ready = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
